// File: rtl/mmio_pwm_timer_if.sv
// mmio_pwm_timer_if: RV32I load/store bus as seen by the MMIO PWM/timer block.
//   master : core side; drives the store strobe, funct3, the addresses and write data.
//   slave  : peripheral side; returns read_data (registered, one cycle after the load address).
// funct3 is shared by loads and stores, as on the core's data port.
interface mmio_pwm_timer_if;
  logic        write_mem;
  logic [2:0]  funct3;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [31:0] read_address;
  logic [31:0] read_data;

  modport master (
    output write_mem, funct3, write_address, write_data, read_address,
    input  read_data
  );

  modport slave (
    input  write_mem, funct3, write_address, write_data, read_address,
    output read_data
  );
endinterface

// File: rtl/mmio_pwm_timer.sv
// mmio_pwm_timer: memory-mapped PWM duty registers plus a millisecond counter.
//   clk, rst_n : single rising-edge clock; asynchronous active-low reset
//   bus        : load/store bus (mmio_pwm_timer_if.slave)
//   led/red/green/blue : registered PWM outputs for duty bytes 0..3
//   irq        : sticky MILLIS==CMP flag when MMIO_TIMER_CMP_EN is defined, else 0
// Register window (BASE_ADDR + offset): 0x0 DUTY, 0x4 CTRL {INV,EN}, 0x8 MILLIS,
// 0xC CMP (present only with MMIO_TIMER_CMP_EN; otherwise reads 0, writes ignored).
module mmio_pwm_timer #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FF00,
  parameter int unsigned CLKS_PER_MS = 12000
) (
  input  logic            clk,
  input  logic            rst_n,
  mmio_pwm_timer_if.slave bus,
  output logic            led,
  output logic            red,
  output logic            green,
  output logic            blue,
  output logic            irq
);

  localparam int unsigned PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_MS - 1);

  logic [PW-1:0] presc;
  logic [31:0]   duty;
  logic [1:0]    ctrl;
  logic [31:0]   millis;
  logic [7:0]    pwm_cnt;
  logic          tick;

  // Byte enables for a store; all-zero for misaligned or reserved funct3.
  function automatic logic [3:0] store_lanes(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    be = '0;
    case (f3)
      3'b000: be = 4'b0001 << a;
      3'b001: if (!a[0]) be = a[1] ? 4'b1100 : 4'b0011;
      3'b010: if (a == 2'b00) be = 4'b1111;
      default: be = '0;
    endcase
    return be;
  endfunction

  // Right-aligned store data is shifted into its lanes; aligned accesses
  // make a single byte-offset shift correct for sb, sh and sw alike.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be, input logic [1:0] a);
    logic [31:0] mask;
    logic [31:0] shifted;
    mask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    shifted = wd << {a, 3'b000};
    return (old & ~mask) | (shifted & mask);
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {a, 3'b000});
    h = 16'(word >> {a[1], 4'b0000});
    r = '0;
    case (f3)
      3'b000: r = {{24{b[7]}}, b};
      3'b100: r = {24'b0, b};
      3'b001: if (!a[0]) r = {{16{h[15]}}, h};
      3'b101: if (!a[0]) r = {16'b0, h};
      3'b010: if (a == 2'b00) r = word;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic pwm_pin(input logic [7:0] cnt, input logic [7:0] d,
                                   input logic [1:0] c);
    return c[0] ? ((cnt < d) ^ c[1]) : c[1];
  endfunction

  // Store decode
  logic        wr_hit;
  logic [3:0]  wr_be;
  logic [1:0]  wr_idx;
  logic [1:0]  wr_lane;
  logic        wr_duty, wr_ctrl, wr_millis;
  logic [31:0] ctrl_merged;

  always_comb begin
    wr_lane     = bus.write_address[1:0];
    wr_idx      = bus.write_address[3:2];
    wr_hit      = bus.write_mem && (bus.write_address[31:4] == BASE_ADDR[31:4]);
    wr_be       = store_lanes(bus.funct3, wr_lane);
    wr_duty     = wr_hit && (|wr_be) && (wr_idx == 2'd0);
    wr_ctrl     = wr_hit && (|wr_be) && (wr_idx == 2'd1);
    wr_millis   = wr_hit && (|wr_be) && (wr_idx == 2'd2);
    ctrl_merged = merge({30'b0, ctrl}, bus.write_data, wr_be, wr_lane);
  end

  assign tick = (presc == PRESC_MAX);

`ifdef MMIO_TIMER_CMP_EN
  logic [31:0] cmp;
  logic        wr_cmp;
  logic        match;

  assign wr_cmp = wr_hit && (|wr_be) && (wr_idx == 2'd3);
  // A store to MILLIS in the tick cycle suppresses the increment, so no match either.
  assign match  = tick && !wr_millis && ((millis + 32'd1) == cmp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp <= '0;
      irq <= 1'b0;
    end else begin
      if (wr_cmp) cmp <= merge(cmp, bus.write_data, wr_be, wr_lane);
      if (match)       irq <= 1'b1;
      else if (wr_cmp) irq <= 1'b0;
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Load path reads pre-store register values
  logic [31:0] rd_word;
  logic        rd_hit;

  always_comb begin
    rd_hit = (bus.read_address[31:4] == BASE_ADDR[31:4]);
    case (bus.read_address[3:2])
      2'd0:    rd_word = duty;
      2'd1:    rd_word = {30'b0, ctrl};
      2'd2:    rd_word = millis;
`ifdef MMIO_TIMER_CMP_EN
      default: rd_word = cmp;
`else
      default: rd_word = '0;
`endif
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.read_data <= '0;
    end else begin
      bus.read_data <= rd_hit ? load_extract(bus.funct3, bus.read_address[1:0], rd_word) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      duty    <= '0;
      ctrl    <= '0;
      millis  <= '0;
      pwm_cnt <= '0;
      led     <= 1'b0;
      red     <= 1'b0;
      green   <= 1'b0;
      blue    <= 1'b0;
    end else begin
      presc   <= tick ? '0 : presc + PW'(1);
      pwm_cnt <= pwm_cnt + 8'd1;
      if (wr_duty) duty <= merge(duty, bus.write_data, wr_be, wr_lane);
      if (wr_ctrl) ctrl <= ctrl_merged[1:0];
      if (wr_millis)  millis <= merge(millis, bus.write_data, wr_be, wr_lane);
      else if (tick)  millis <= millis + 32'd1;
      led   <= pwm_pin(pwm_cnt, duty[7:0],   ctrl);
      red   <= pwm_pin(pwm_cnt, duty[15:8],  ctrl);
      green <= pwm_pin(pwm_cnt, duty[23:16], ctrl);
      blue  <= pwm_pin(pwm_cnt, duty[31:24], ctrl);
    end
  end

endmodule

// File: tb/tb_mmio_pwm_timer.sv
// tb_mmio_pwm_timer: scoreboard bench for mmio_pwm_timer (CLKS_PER_MS = 4).
module tb_mmio_pwm_timer;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic clk;
  logic rst_n;
  logic led, red, green, blue, irq;

  mmio_pwm_timer_if bus ();

  mmio_pwm_timer #(.BASE_ADDR(BASE), .CLKS_PER_MS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .led   (led),
    .red   (red),
    .green (green),
    .blue  (blue),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle; an expected load result is queued at drive time and
  // compared against read_data after the edge that registers it.
  task automatic bus_cycle(input logic we, input logic [2:0] f3, input logic [31:0] waddr,
                           input logic [31:0] wdata, input logic [31:0] raddr,
                           input logic chk, input logic [31:0] exp, input string tag);
    bus.write_mem     = we;
    bus.funct3        = f3;
    bus.write_address = waddr;
    bus.write_data    = wdata;
    bus.read_address  = raddr;
    if (chk) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    @(posedge clk);
    #1;
    bus.write_mem = 1'b0;
    if (chk) begin
      if (exp_q.size() == 0) check_eq("sb_empty", 32'd0, 32'd1);
      else check_eq(tag_q.pop_front(), bus.read_data, exp_q.pop_front());
    end
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] off, input logic [31:0] data);
    bus_cycle(1'b1, f3, BASE + off, data, BASE, 1'b0, '0, "");
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] off, input logic [31:0] exp,
                    input string tag);
    bus_cycle(1'b0, f3, BASE, '0, BASE + off, 1'b1, exp, tag);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.write_mem = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic count_pins(input int n, output int cl, output int cr, output int cg,
                            output int cb);
    cl = 0; cr = 0; cg = 0; cb = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cl += int'(led); cr += int'(red); cg += int'(green); cb += int'(blue);
    end
  endtask

  int cl, cr, cg, cb;

  initial begin
    rst_n             = 1'b0;
    bus.write_mem     = 1'b0;
    bus.funct3        = LW;
    bus.write_address = '0;
    bus.write_data    = '0;
    bus.read_address  = '0;

    // Reset state
    do_reset();
    ld(LW, 32'h0, 32'h0, "rst_duty");
    check_eq("rst_pins0", {28'b0, led, red, green, blue}, 32'h0);
    ld(LW, 32'h4, 32'h0, "rst_ctrl");
    check_eq("rst_pins1", {28'b0, led, red, green, blue}, 32'h0);
    ld(LW, 32'h8, 32'h0, "rst_millis");
    check_eq("rst_pins2", {28'b0, led, red, green, blue}, 32'h0);
    check_eq("rst_irq", {31'b0, irq}, 32'h0);

    // PWM duty counts over two full periods
    do_reset();
    st(LW, 32'h0, 32'h40FF_0080);
    st(LW, 32'h4, 32'h1);
    @(posedge clk); #1;
    count_pins(512, cl, cr, cg, cb);
    check_eq("pwm_led",   cl, 256);
    check_eq("pwm_red",   cr, 0);
    check_eq("pwm_green", cg, 510);
    check_eq("pwm_blue",  cb, 128);

    // Inversion with EN, then inverted idle with EN clear
    do_reset();
    st(LW, 32'h4, 32'h3);
    @(posedge clk); #1;
    count_pins(300, cl, cr, cg, cb);
    check_eq("inv_en_pins", cl + cr + cg + cb, 1200);
    st(LW, 32'h4, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    count_pins(300, cl, cr, cg, cb);
    check_eq("inv_idle_pins", cl + cr + cg + cb, 1200);
    ld(LW, 32'h4, 32'h2, "ctrl_rb");

    // Byte/half lanes, sign/zero extension, misaligned, reserved, misses
    do_reset();
    st(LB, 32'h2, 32'h1234_56A5);
    ld(LW,  32'h0, 32'h00A5_0000, "sb_lw");
    ld(LB,  32'h2, 32'hFFFF_FFA5, "lb");
    ld(LBU, 32'h2, 32'h0000_00A5, "lbu");
    st(LH, 32'h1, 32'h0000_BEEF);
    ld(LW,  32'h0, 32'h00A5_0000, "sh_misal");
    ld(LW,  32'h2, 32'h0, "lw_misal");
    st(LH, 32'h2, 32'h0000_8001);
    ld(LH,  32'h2, 32'hFFFF_8001, "lh");
    ld(LHU, 32'h2, 32'h0000_8001, "lhu");
    ld(LH,  32'h1, 32'h0, "lh_misal");
    ld(3'b011, 32'h0, 32'h0, "ld_resv");
    st(LW, 32'h3, 32'hFFFF_FFFF);
    bus_cycle(1'b1, LW, BASE + 32'h10, 32'hFFFF_FFFF, BASE, 1'b0, '0, "");
    bus_cycle(1'b1, 3'b011, BASE, 32'hFFFF_FFFF, BASE, 1'b0, '0, "");
    ld(LW,  32'h0, 32'h8001_0000, "st_ignored");
    ld(LW,  32'h10, 32'h0, "ld_miss");
    bus_cycle(1'b1, LW, BASE, 32'h1122_3344, BASE, 1'b1, 32'h8001_0000, "same_cycle");
    ld(LW,  32'h0, 32'h1122_3344, "after_store");

    // MILLIS prescale, wrap, and store in tick cycle (ticks at edges 4,8,..)
    do_reset();
    bus.funct3       = LW;
    bus.read_address = BASE + 32'h8;
    repeat (12) @(posedge clk);
    #1;
    ld(LW, 32'h8, 32'd3, "millis_12");            // edge 13
    st(LW, 32'h8, 32'hFFFF_FFFF);                 // edge 14, not a tick
    ld(LW, 32'h8, 32'hFFFF_FFFF, "millis_st");    // edge 15
    ld(LW, 32'h8, 32'hFFFF_FFFF, "millis_pre");   // edge 16 (tick)
    ld(LW, 32'h8, 32'h0, "millis_wrap");          // edge 17
    repeat (2) @(posedge clk);
    #1;
    st(LW, 32'h8, 32'h55);                        // edge 20, tick cycle
    for (int i = 0; i < 4; i++) ld(LW, 32'h8, 32'h55, "millis_tickst");
    ld(LW, 32'h8, 32'h56, "millis_next");         // edge 25

`ifdef MMIO_TIMER_CMP_EN
    do_reset();
    st(LW, 32'hC, 32'd2);                         // edge 1
    repeat (6) @(posedge clk);
    #1;
    check_eq("irq_before", {31'b0, irq}, 32'h0);  // after edge 7
    @(posedge clk); #1;
    check_eq("irq_set", {31'b0, irq}, 32'h1);     // edge 8: MILLIS -> 2
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("irq_hold", {31'b0, irq}, 32'h1);
    end
    st(LW, 32'hC, 32'd5);                         // edge 14
    check_eq("irq_clr", {31'b0, irq}, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    check_eq("irq_set5", {31'b0, irq}, 32'h1);    // edge 20: MILLIS -> 5
`else
    st(LW, 32'hC, 32'd7);
    ld(LW, 32'hC, 32'h0, "cmp_absent");
    check_eq("irq_tied", {31'b0, irq}, 32'h0);
`endif

    // Asynchronous reset mid-run
    st(LW, 32'h4, 32'h3);
    ld(LW, 32'h4, 32'h3, "ctrl_pre_rst");
    check_eq("pins_pre_rst", {28'b0, led, red, green, blue}, 32'hF);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_pins", {28'b0, led, red, green, blue}, 32'h0);
    check_eq("rst_async_rd", bus.read_data, 32'h0);
    check_eq("rst_async_irq", {31'b0, irq}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ld(LW, 32'h8, 32'h0, "rst_async_millis");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
